// File: rtl/root_checker.sv
// root_checker: bit-serial verifier for candidate square and cube roots.
// Optional macro ROOT_CHECK_NEXT_EN: also flag roots that are not the floor root.
`timescale 1ns/1ps
module root_checker #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] number,
    input  logic [WIDTH-1:0] sq_root,
    input  logic [WIDTH-1:0] cube_root,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             is_square,
    output logic             is_cube,
    output logic [WIDTH-1:0] sq_rem,
    output logic [WIDTH-1:0] cb_rem,
    output logic             root_err
);

    localparam int W2 = 2 * WIDTH;
    localparam int W3 = 3 * WIDTH;
    localparam int CW = $clog2(WIDTH) + 1;
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    typedef enum logic [2:0] {
        IDLE,
        MUL_SQ,
        MUL_C2,
        MUL_C3,
        CMP,
        HOLD
    } state_t;

    state_t r_state;
    state_t w_state_nxt;

    logic             r_init;
    logic [WIDTH-1:0] r_num;
    logic [WIDTH-1:0] r_cr;
    logic [CW-1:0]    r_cnt;
    logic [W3-1:0]    r_mcand;
    logic [W3-1:0]    r_acc;
    logic [WIDTH-1:0] r_mplier;
    logic [W2-1:0]    r_sq;
    logic [W3-1:0]    r_c3;

    logic             r_out_valid;
    logic             r_is_square;
    logic             r_is_cube;
    logic [WIDTH-1:0] r_sq_rem;
    logic [WIDTH-1:0] r_cb_rem;
    logic             r_root_err;

    logic             w_accept;
    logic             w_mul;
    logic             w_last;
    logic [W3-1:0]    w_acc_sum;
    logic [W2-1:0]    w_num2;
    logic [W3-1:0]    w_num3;
    logic             w_sq_eq;
    logic             w_sq_over;
    logic             w_cb_eq;
    logic             w_cb_over;
    logic [WIDTH-1:0] w_sq_diff;
    logic [WIDTH-1:0] w_cb_diff;
    logic             w_cmp_done;
    logic             w_low;

    assign w_accept  = in_valid & in_ready;
    assign w_mul     = (r_state == MUL_SQ) |
                       (r_state == MUL_C2) |
                       (r_state == MUL_C3);
    assign w_last    = (r_cnt == LAST);
    assign w_acc_sum = r_acc + (r_mplier[0] ? r_mcand : '0);

    assign w_num2    = W2'(r_num);
    assign w_num3    = W3'(r_num);
    assign w_sq_eq   = (r_sq == w_num2);
    assign w_sq_over = (r_sq > w_num2);
    assign w_cb_eq   = (r_c3 == w_num3);
    assign w_cb_over = (r_c3 > w_num3);
    assign w_sq_diff = r_num - r_sq[WIDTH-1:0];
    assign w_cb_diff = r_num - r_c3[WIDTH-1:0];

`ifdef ROOT_CHECK_NEXT_EN
    localparam int W2P = W2 + 1;
    localparam int W3P = W3 + 1;

    logic             r_cmp_ph;
    logic [WIDTH-1:0] r_sr;
    logic [W2-1:0]    r_c2;
    logic [W2P-1:0]   r_sq_nx;
    logic [W3P-1:0]   r_cb_nx;
    logic [W2P-1:0]   w_sq_nx;
    logic [W3P-1:0]   w_cb_nx;

    // (s+1)^2 = S + 2s + 1 and (c+1)^3 = C3 + 3*C2 + 3c + 1, one bit wider
    assign w_sq_nx = W2P'(r_sq)
                   + (W2P'(r_sr) << 1)
                   + W2P'(1);
    assign w_cb_nx = W3P'(r_c3)
                   + W3P'(r_c2)
                   + (W3P'(r_c2) << 1)
                   + W3P'(r_cr)
                   + (W3P'(r_cr) << 1)
                   + W3P'(1);

    assign w_cmp_done = r_cmp_ph;
    assign w_low      = (r_sq_nx <= W2P'(r_num)) |
                        (r_cb_nx <= W3P'(r_num));

    // Square-root capture and C2 retention feed the next-root adders
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sr <= '0;
            r_c2 <= '0;
        end else begin
            if (w_accept) begin
                r_sr <= sq_root;
            end
            if (r_state == MUL_C2 && w_last) begin
                r_c2 <= w_acc_sum[W2-1:0];
            end
        end
    end

    // First CMP cycle registers the next-root values, second one reports
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cmp_ph <= 1'b0;
            r_sq_nx  <= '0;
            r_cb_nx  <= '0;
        end else if (r_state == CMP) begin
            r_cmp_ph <= ~r_cmp_ph;
            if (!r_cmp_ph) begin
                r_sq_nx <= w_sq_nx;
                r_cb_nx <= w_cb_nx;
            end
        end else begin
            r_cmp_ph <= 1'b0;
        end
    end
`else
    assign w_cmp_done = 1'b1;
    assign w_low      = 1'b0;
`endif

    // State register plus the post-reset ready enable
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
            r_init  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_init  <= 1'b1;
        end
    end

    // Next-state decode; only IDLE accepts a new triple
    always_comb begin
        w_state_nxt = r_state;
        in_ready    = 1'b0;
        unique case (r_state)
            IDLE: begin
                in_ready = r_init;
                if (in_valid && r_init) begin
                    w_state_nxt = MUL_SQ;
                end
            end
            MUL_SQ: begin
                if (w_last) begin
                    w_state_nxt = MUL_C2;
                end
            end
            MUL_C2: begin
                if (w_last) begin
                    w_state_nxt = MUL_C3;
                end
            end
            MUL_C3: begin
                if (w_last) begin
                    w_state_nxt = CMP;
                end
            end
            CMP: begin
                if (w_cmp_done) begin
                    w_state_nxt = HOLD;
                end
            end
            HOLD: begin
                if (out_ready) begin
                    w_state_nxt = IDLE;
                end
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    // Capture the operand and cube root that the later passes reuse
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_num <= '0;
            r_cr  <= '0;
        end else if (w_accept) begin
            r_num <= number;
            r_cr  <= cube_root;
        end
    end

    // Shift-add multiplier: one multiplier bit per cycle, LSB first
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_acc    <= '0;
            r_mcand  <= '0;
            r_mplier <= '0;
            r_cnt    <= '0;
        end else if (w_accept) begin
            r_acc    <= '0;
            r_mcand  <= W3'(sq_root);
            r_mplier <= sq_root;
            r_cnt    <= '0;
        end else if (w_mul) begin
            if (w_last) begin
                r_acc    <= '0;
                r_cnt    <= '0;
                r_mplier <= r_cr;
                r_mcand  <= (r_state == MUL_SQ) ? W3'(r_cr) : w_acc_sum;
            end else begin
                r_acc    <= w_acc_sum;
                r_mcand  <= r_mcand << 1;
                r_mplier <= r_mplier >> 1;
                r_cnt    <= r_cnt + CW'(1);
            end
        end
    end

    // Keep the finished S and C3 products for the compare stage
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sq <= '0;
            r_c3 <= '0;
        end else if (w_mul && w_last) begin
            if (r_state == MUL_SQ) begin
                r_sq <= w_acc_sum[W2-1:0];
            end
            if (r_state == MUL_C3) begin
                r_c3 <= w_acc_sum;
            end
        end
    end

    // Result register: loaded at the end of CMP, valid dropped on handoff
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_out_valid <= 1'b0;
            r_is_square <= 1'b0;
            r_is_cube   <= 1'b0;
            r_sq_rem    <= '0;
            r_cb_rem    <= '0;
            r_root_err  <= 1'b0;
        end else if (r_state == CMP && w_cmp_done) begin
            r_out_valid <= 1'b1;
            r_is_square <= w_sq_eq;
            r_is_cube   <= w_cb_eq;
            r_sq_rem    <= w_sq_over ? '0 : w_sq_diff;
            r_cb_rem    <= w_cb_over ? '0 : w_cb_diff;
            r_root_err  <= w_sq_over | w_cb_over | w_low;
        end else if (r_state == HOLD && out_ready) begin
            r_out_valid <= 1'b0;
        end
    end

    assign out_valid = r_out_valid;
    assign is_square = r_is_square;
    assign is_cube   = r_is_cube;
    assign sq_rem    = r_sq_rem;
    assign cb_rem    = r_cb_rem;
    assign root_err  = r_root_err;

endmodule

// File: tb/tb_root_checker.sv
// tb_root_checker: directed and random triples against an arithmetic model.
// Build with ROOT_CHECK_NEXT_EN defined to check the floor-root variant.
`timescale 1ns/1ps
module tb_root_checker;

    localparam int W = 32;
`ifdef ROOT_CHECK_NEXT_EN
    localparam int LAT = 3 * W + 2;
    localparam bit NEXT = 1'b1;
`else
    localparam int LAT = 3 * W + 1;
    localparam bit NEXT = 1'b0;
`endif

    typedef struct packed {
        logic         sq;
        logic         cb;
        logic [W-1:0] srem;
        logic [W-1:0] crem;
        logic         err;
    } exp_t;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] number;
    logic [W-1:0] sq_root;
    logic [W-1:0] cube_root;
    logic         out_valid;
    logic         out_ready;
    logic         is_square;
    logic         is_cube;
    logic [W-1:0] sq_rem;
    logic [W-1:0] cb_rem;
    logic         root_err;

    int checks = 0;
    int failures = 0;

    root_checker #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .number    (number),
        .sq_root   (sq_root),
        .cube_root (cube_root),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .is_square (is_square),
        .is_cube   (is_cube),
        .sq_rem    (sq_rem),
        .cb_rem    (cb_rem),
        .root_err  (root_err)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [127:0] obs,
                         input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic exp_t mk(input logic sq, input logic cb,
                                input logic [W-1:0] srem,
                                input logic [W-1:0] crem,
                                input logic err);
        exp_t e;
        e.sq = sq; e.cb = cb; e.srem = srem; e.crem = crem; e.err = err;
        return e;
    endfunction

    // Plain wide-integer arithmetic straight from the root definitions
    function automatic exp_t model(input logic [W-1:0] n,
                                   input logic [W-1:0] s,
                                   input logic [W-1:0] c);
        logic [127:0] nn, ss, cc;
        exp_t e;
        nn = 128'(n);
        ss = 128'(s) * 128'(s);
        cc = 128'(c) * 128'(c) * 128'(c);
        e.sq   = (ss == nn);
        e.cb   = (cc == nn);
        e.srem = (ss > nn) ? '0 : W'(nn - ss);
        e.crem = (cc > nn) ? '0 : W'(nn - cc);
        e.err  = (ss > nn) || (cc > nn);
`ifdef ROOT_CHECK_NEXT_EN
        begin
            logic [127:0] sn, cn;
            sn = (128'(s) + 1) * (128'(s) + 1);
            cn = (128'(c) + 1) * (128'(c) + 1) * (128'(c) + 1);
            e.err = e.err || (sn <= nn) || (cn <= nn);
        end
`endif
        return e;
    endfunction

    task automatic run_txn(input string tag, input logic [W-1:0] n,
                           input logic [W-1:0] s, input logic [W-1:0] c,
                           input int bp, input exp_t e);
        int edges;
        bit busy_rdy;
        edges = 0;
        while (!in_ready && edges < 10) begin
            step();
            edges++;
        end
        check({tag, ".rdy_idle"}, in_ready, 1);
        in_valid  = 1'b1;
        number    = n;
        sq_root   = s;
        cube_root = c;
        step();
        edges    = 0;
        busy_rdy = 1'b0;
        do begin
            if (in_ready) busy_rdy = 1'b1;
            in_valid  = 1'($urandom_range(0, 1));
            number    = $urandom;
            sq_root   = $urandom;
            cube_root = $urandom;
            step();
            edges++;
        end while (!out_valid && edges < 300);
        in_valid = 1'b0;
        check({tag, ".latency"}, edges, LAT);
        check({tag, ".busy_rdy"}, busy_rdy, 0);
        check({tag, ".is_square"}, is_square, e.sq);
        check({tag, ".is_cube"}, is_cube, e.cb);
        check({tag, ".sq_rem"}, sq_rem, e.srem);
        check({tag, ".cb_rem"}, cb_rem, e.crem);
        check({tag, ".root_err"}, root_err, e.err);
        for (int i = 0; i < bp; i++) begin
            out_ready = 1'b0;
            step();
            check({tag, ".bp_valid"}, out_valid, 1);
            check({tag, ".bp_rdy"}, in_ready, 0);
            check({tag, ".bp_stable"},
                  {is_square, is_cube, sq_rem, cb_rem, root_err}, e);
        end
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        check({tag, ".rel_valid"}, out_valid, 0);
        check({tag, ".rel_rdy"}, in_ready, 1);
    endtask

    initial begin
        logic [W-1:0] n, s, c;
        int mode;
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        number    = '0;
        sq_root   = '0;
        cube_root = '0;
        #12;
        check("rst.outs",
              {out_valid, is_square, is_cube, sq_rem, cb_rem, root_err}, 0);
        rst_n = 1'b1;
        step();
        check("rst.rdy", in_ready, 1);

        run_txn("t27_5_3", 32'd27, 32'd5, 32'd3, 5,
                mk(1'b0, 1'b1, 32'd2, 32'd0, 1'b0));
        run_txn("t16_4_2", 32'd16, 32'd4, 32'd2, 0,
                mk(1'b1, 1'b0, 32'd0, 32'd8, 1'b0));
        run_txn("t10_4_2", 32'd10, 32'd4, 32'd2, 1,
                mk(1'b0, 1'b0, 32'd0, 32'd2, 1'b1));
        run_txn("tmax", 32'hFFFF_FFFF, 32'd65535, 32'd1625, 0,
                mk(1'b0, 1'b0, 32'd131070, 32'd3951670, 1'b0));
        run_txn("tzero", 32'd0, 32'd0, 32'd0, 0,
                mk(1'b1, 1'b1, 32'd0, 32'd0, 1'b0));
        run_txn("tbigroot", 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0,
                mk(1'b0, 1'b0, 32'd0, 32'd0, 1'b1));
        run_txn("t27_3_3", 32'd27, 32'd3, 32'd3, 2,
                mk(1'b0, 1'b1, 32'd18, 32'd0, NEXT));

        in_valid  = 1'b1;
        number    = 32'd100;
        sq_root   = 32'd10;
        cube_root = 32'd4;
        step();
        in_valid = 1'b0;
        for (int i = 0; i < 40; i++) step();
        check("midrst.pre_valid", out_valid, 0);
        rst_n = 1'b0;
        #1;
        check("midrst.outs",
              {out_valid, is_square, is_cube, sq_rem, cb_rem, root_err}, 0);
        #2;
        rst_n = 1'b1;
        step();
        check("midrst.rdy", in_ready, 1);
        check("midrst.valid", out_valid, 0);

        run_txn("t8_2_2", 32'd8, 32'd2, 32'd2, 0,
                mk(1'b0, 1'b1, 32'd4, 32'd0, 1'b0));

        for (int k = 0; k < 10; k++) begin
            mode = $urandom_range(0, 3);
            s = $urandom_range(0, 65535);
            c = $urandom_range(0, 1625);
            n = $urandom;
            if (mode == 1) n = s * s;
            if (mode == 2) begin
                s = $urandom;
                c = $urandom;
            end
            if (mode == 3) n = c * c * c + W'($urandom_range(0, 5));
            run_txn($sformatf("rnd%0d", k), n, s, c,
                    $urandom_range(0, 3), model(n, s, c));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
